// File: rtl/scan_pkg.sv
// scan_pkg: shared state encodings and slot geometry for scan sequencers
package scan_pkg;
  localparam int NUM_SLOTS = 4;
  localparam int SLOT_W = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, DWELL = 2'd1, BLANK = 2'd2} state_t;
endpackage

// File: rtl/next_slot_sel.sv
// next_slot_sel: next set mask bit above cur (wrapping), with wrap and empty-mask flags
module next_slot_sel
  import scan_pkg::*;
(
  input  logic [SLOT_W-1:0]    cur,
  input  logic [NUM_SLOTS-1:0] mask,
  output logic [SLOT_W-1:0]    nxt,
  output logic                 wrap,
  output logic                 none
);
  always_comb begin
    nxt = cur;
    for (int i = NUM_SLOTS; i >= 1; i--)
      if (mask[cur + SLOT_W'(i)]) nxt = cur + SLOT_W'(i);
  end
  assign wrap = nxt <= cur;
  assign none = ~|mask;
endmodule

// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: round-robin 4-slot scan with dwell/blank timing; SCAN_FREEZE_EN adds a freeze input
module digit_scan_ctrl
  import scan_pkg::*;
#(
  parameter int DWELL_W = 16,
  parameter int BLANK_CYC = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
`ifdef SCAN_FREEZE_EN
  input  logic                 freeze,
`endif
  input  logic [NUM_SLOTS-1:0] digit_mask,
  input  logic [DWELL_W-1:0]   dwell,
  output logic [SLOT_W-1:0]    sel,
  output logic                 sel_valid,
  output logic                 frame_start
);
  localparam int BW = BLANK_CYC > 0 ? $clog2(BLANK_CYC + 1) : 1;
  state_t state, state_n;
  logic [SLOT_W-1:0] sel_n, nxt;
  logic [DWELL_W-1:0] dcnt, dcnt_n, dwell_ld;
  logic [BW-1:0] bcnt, bcnt_n;
  logic valid_n, fs_n, adv, wrap, none, frz;
`ifdef SCAN_FREEZE_EN
  assign frz = freeze;
`else
  assign frz = 1'b0;
`endif
  // From IDLE, searching above slot 3 yields the lowest set bit
  next_slot_sel u_next (
    .cur  (state == IDLE ? SLOT_W'(NUM_SLOTS - 1) : sel),
    .mask (digit_mask),
    .nxt  (nxt),
    .wrap (wrap),
    .none (none)
  );
  // Counters hold cycles remaining, so dwell 0 and 1 both load 0
  assign dwell_ld = dwell == '0 ? '0 : dwell - DWELL_W'(1);
  always_comb begin
    state_n = state;
    sel_n = sel;
    valid_n = sel_valid;
    fs_n = 1'b0;
    dcnt_n = dcnt;
    bcnt_n = bcnt;
    adv = 1'b0;
    if (!en) begin
      state_n = IDLE;
      valid_n = 1'b0;
      dcnt_n = '0;
      bcnt_n = '0;
    end else if (frz && state != IDLE) begin
      fs_n = 1'b0;
    end else if (state == IDLE) begin
      adv = !none;
    end else if (state == DWELL && dcnt != '0) begin
      dcnt_n = dcnt - DWELL_W'(1);
    end else if (state == DWELL && BLANK_CYC > 0) begin
      state_n = BLANK;
      valid_n = 1'b0;
      bcnt_n = BW'(BLANK_CYC - 1);
    end else if (state == BLANK && bcnt != '0) begin
      bcnt_n = bcnt - BW'(1);
    end else begin
      adv = 1'b1;
    end
    if (adv) begin
      state_n = none ? IDLE : DWELL;
      sel_n = none ? sel : nxt;
      valid_n = !none;
      fs_n = !none && (wrap || state == IDLE);
      dcnt_n = dwell_ld;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sel <= '0;
      sel_valid <= 1'b0;
      frame_start <= 1'b0;
      dcnt <= '0;
      bcnt <= '0;
    end else begin
      state <= state_n;
      sel <= sel_n;
      sel_valid <= valid_n;
      frame_start <= fs_n;
      dcnt <= dcnt_n;
      bcnt <= bcnt_n;
    end
  end
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: directed scoreboard bench for digit_scan_ctrl (default build, BLANK_CYC=2)
module tb_digit_scan_ctrl;
  typedef struct {
    logic [1:0] s;
    logic       v;
    logic       f;
    string      tag;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0;
  logic [3:0] digit_mask = 4'h0;
  logic [15:0] dwell = 16'd0;
  logic [1:0] sel;
  logic sel_valid, frame_start;
  exp_t q[$];
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  digit_scan_ctrl #(.DWELL_W(16), .BLANK_CYC(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .digit_mask  (digit_mask),
    .dwell       (dwell),
    .sel         (sel),
    .sel_valid   (sel_valid),
    .frame_start (frame_start)
  );
  // Pattern chars, one per cycle: '0'-'3' valid slot, 'A'-'D' valid slot with frame_start,
  // 'w'-'z' not valid with sel held at 0-3
  task automatic run(input logic r, input logic e, input logic [3:0] m, input logic [15:0] d,
                     input string tag, input string p);
    for (int i = 0; i < p.len(); i++) begin
      byte c;
      exp_t x;
      rst = r;
      en = e;
      digit_mask = m;
      dwell = d;
      @(posedge clk);
      c = p[i];
      x.tag = $sformatf("%s[%0d]", tag, i);
      if (c >= "0" && c <= "3") begin x.s = 2'(c - "0"); x.v = 1'b1; x.f = 1'b0; end
      else if (c >= "A" && c <= "D") begin x.s = 2'(c - "A"); x.v = 1'b1; x.f = 1'b1; end
      else begin x.s = 2'(c - "w"); x.v = 1'b0; x.f = 1'b0; end
      q.push_back(x);
      #1;
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t x;
      x = q.pop_front();
      checks++;
      if (sel !== x.s || sel_valid !== x.v || frame_start !== x.f) begin
        errors++;
        $display("FAIL %s: sel/valid/frame_start got %0d/%0b/%0b expected %0d/%0b/%0b",
                 x.tag, sel, sel_valid, frame_start, x.s, x.v, x.f);
      end
    end
  end
  initial begin
    run(1, 0, 4'h0, 16'd0, "reset", "ww");
    run(0, 0, 4'hf, 16'd3, "en_low", "ww");
    run(0, 1, 4'h0, 16'd3, "mask_zero", "ww");
    run(0, 1, 4'hf, 16'd3, "full", "A00ww111xx222yy333zzA00ww111xx");
    run(1, 0, 4'h0, 16'd0, "rst1", "w");
    run(0, 1, 4'ha, 16'd2, "mask_a", "B1xx33zzB1xx33zzB1");
    run(1, 0, 4'h0, 16'd0, "rst2", "w");
    run(0, 1, 4'h4, 16'd0, "single", "CyyCyyCyyCyy");
    run(1, 0, 4'h0, 16'd0, "rst3", "w");
    run(0, 1, 4'hf, 16'd3, "en_drop_a", "A00ww11");
    run(0, 0, 4'hf, 16'd3, "en_drop_b", "xx");
    run(0, 1, 4'hf, 16'd3, "en_drop_c", "A00");
    run(1, 0, 4'h0, 16'd0, "rst4", "w");
    run(0, 1, 4'hf, 16'd3, "rst_blank_a", "A00ww111xx222y");
    run(1, 1, 4'hf, 16'd3, "rst_blank_b", "w");
    run(0, 1, 4'hf, 16'd3, "rst_blank_c", "A00");
    run(1, 0, 4'h0, 16'd0, "rst5", "w");
    run(0, 1, 4'hf, 16'd3, "mask_clr_a", "A00ww111xx2");
    run(0, 1, 4'h0, 16'd3, "mask_clr_b", "22yyyyy");
    run(1, 0, 4'h0, 16'd0, "rst6", "w");
    run(0, 1, 4'hf, 16'd3, "dwell_chg_a", "A0");
    run(0, 1, 4'hf, 16'd1, "dwell_chg_b", "0ww1xx2yy3zzA");
    repeat (4) @(negedge clk);
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: queue entries left %0d expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
